// File: rtl/cr_xer_write_back_arbiter_pkg.sv
// cr_xer_write_back_arbiter_pkg: shared types for the CR0/XER write-back path
package cr_xer_write_back_arbiter_pkg;
  localparam int RS_ID_WIDTH = 5;
  typedef struct packed {
    logic [3:0] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;
  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic                   write_cr0;
    logic                   write_xer;
    cond_exception_t        cr0_xer;
  } cr_xer_wb_entry_t;
endpackage

// File: rtl/cr_xer_write_back_arbiter_rr_grant.sv
// cr_xer_write_back_arbiter_rr_grant: combinational round-robin priority encoder
module cr_xer_write_back_arbiter_rr_grant #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          valid_o
);
  // Scan from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    grant_o = '0;
    grant_idx_o = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        grant_idx_o = PW'((int'(ptr_i) + k) % N);
        valid_o = 1'b1;
      end
    end
    if (valid_o) grant_o[grant_idx_o] = 1'b1;
  end
endmodule

// File: rtl/cr_xer_write_back_arbiter.sv
// cr_xer_write_back_arbiter: round-robin CR0/XER write-back arbiter with a 2-entry output queue
module cr_xer_write_back_arbiter
  import cr_xer_write_back_arbiter_pkg::*;
#(
  parameter int ARBITER_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ARBITER_DEPTH-1:0] input_valid,
  output logic [ARBITER_DEPTH-1:0] input_ready,
  input  logic [RS_ID_WIDTH-1:0]   rs_id_in [ARBITER_DEPTH],
  input  logic [ARBITER_DEPTH-1:0] write_cr0_in,
  input  logic [ARBITER_DEPTH-1:0] write_xer_in,
  input  cond_exception_t          cr0_xer_in [ARBITER_DEPTH],
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [RS_ID_WIDTH-1:0]   rs_id_out,
  output cond_exception_t          cr0_xer_out,
  output logic                     cr_write_enable_0,
  output logic                     xer_write_enable
);
  localparam int PW = (ARBITER_DEPTH > 1) ? $clog2(ARBITER_DEPTH) : 1;
  logic [ARBITER_DEPTH-1:0] req, grant;
  logic [PW-1:0] grant_idx, rr_ptr_q, rr_ptr_d;
  logic grant_valid, pop, can_push, push;
  logic [1:0] count_q, count_d, wp;
  cr_xer_wb_entry_t q_q [2], q_d [2], new_entry;

  assign req = input_valid & (write_cr0_in | write_xer_in);

  cr_xer_write_back_arbiter_rr_grant #(.N(ARBITER_DEPTH), .PW(PW)) u_rr_grant (
    .req_i(req), .ptr_i(rr_ptr_q), .grant_o(grant), .grant_idx_o(grant_idx), .valid_o(grant_valid)
  );

  assign output_valid      = count_q != 2'd0;
  assign rs_id_out         = q_q[0].rs_id;
  assign cr0_xer_out       = q_q[0].cr0_xer;
  assign cr_write_enable_0 = output_valid & q_q[0].write_cr0;
  assign xer_write_enable  = output_valid & q_q[0].write_xer;
  assign pop               = output_valid & output_ready;
  assign can_push          = (count_q < 2'd2) | pop;
  assign push              = grant_valid & can_push & ~rst;
  // Zero-effect results are retired here and never occupy a queue slot.
  assign input_ready = rst ? '0 : (input_valid & ~(write_cr0_in | write_xer_in)) | (can_push ? grant : '0);
  assign new_entry   = '{rs_id: rs_id_in[grant_idx], write_cr0: write_cr0_in[grant_idx],
                         write_xer: write_xer_in[grant_idx], cr0_xer: cr0_xer_in[grant_idx]};
  assign wp          = count_q - {1'b0, pop};
  assign count_d     = count_q + {1'b0, push} - {1'b0, pop};
  assign rr_ptr_d    = !push ? rr_ptr_q : (int'(grant_idx) == ARBITER_DEPTH - 1) ? '0 : grant_idx + 1'b1;

  // Head stays put when the queue drains so the outputs keep their last value.
  always_comb begin
    q_d = q_q;
    if (pop && count_q == 2'd2) q_d[0] = q_q[1];
    if (push) q_d[wp[0]] = new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rr_ptr_q <= '0;
      q_q[0]   <= '0;
      q_q[1]   <= '0;
    end else begin
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      q_q      <= q_d;
    end
  end
endmodule

// File: tb/tb_cr_xer_write_back_arbiter.sv
// tb_cr_xer_write_back_arbiter: directed scenarios plus a random run against a queue-level model
module tb_cr_xer_write_back_arbiter;
  import cr_xer_write_back_arbiter_pkg::*;
  logic clk = 0, rst = 0;
  logic [1:0] iv = 0, ir, wc = 0, wx = 0;
  logic [4:0] rid [2];
  cond_exception_t ce [2];
  logic ov, ordy = 0, cwe, xwe;
  logic [4:0] rso;
  cond_exception_t ceo;
  logic [2:0] iv3 = 0, ir3, wc3 = 0, wx3 = 0;
  logic [4:0] rid3 [3];
  cond_exception_t ce3 [3];
  logic ov3, ordy3 = 1, cwe3, xwe3;
  logic [4:0] rso3;
  cond_exception_t ceo3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cr_xer_write_back_arbiter #(.ARBITER_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .input_valid(iv), .input_ready(ir), .rs_id_in(rid),
    .write_cr0_in(wc), .write_xer_in(wx), .cr0_xer_in(ce), .output_valid(ov),
    .output_ready(ordy), .rs_id_out(rso), .cr0_xer_out(ceo),
    .cr_write_enable_0(cwe), .xer_write_enable(xwe)
  );

  cr_xer_write_back_arbiter #(.ARBITER_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .input_valid(iv3), .input_ready(ir3), .rs_id_in(rid3),
    .write_cr0_in(wc3), .write_xer_in(wx3), .cr0_xer_in(ce3), .output_valid(ov3),
    .output_ready(ordy3), .rs_id_out(rso3), .cr0_xer_out(ceo3),
    .cr_write_enable_0(cwe3), .xer_write_enable(xwe3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; iv = 0; iv3 = 0; wc = 0; wx = 0; ordy = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; iv = 2'b11; wc = 2'b11; rid[0] = 1; rid[1] = 2; ce[0] = '0; ce[1] = '0;
    #1;
    checks++; if (ir !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", ir); end
    tick();
    rst = 0; iv = 0; wc = 0;
    #1;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ov); end
    checks++; if ({cwe, xwe} !== 2'b00) begin errors++; $display("FAIL reset_we got %b exp 00", {cwe, xwe}); end
    checks++; if (rso !== 5'd0) begin errors++; $display("FAIL reset_rsid got %0d exp 0", rso); end
    checks++; if (ceo !== '0) begin errors++; $display("FAIL reset_ce got %h exp 0", ceo); end
  endtask

  task automatic test_single();
    do_reset();
    iv = 2'b01; wc = 2'b01; wx = 0; rid[0] = 3; ce[0] = 7'h55;
    #1;
    checks++; if (ir !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", ir); end
    tick();
    iv = 0;
    #1;
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ov); end
    checks++; if (rso !== 5'd3) begin errors++; $display("FAIL single_rsid got %0d exp 3", rso); end
    checks++; if ({cwe, xwe} !== 2'b10) begin errors++; $display("FAIL single_we got %b exp 10", {cwe, xwe}); end
    checks++; if (ceo !== 7'h55) begin errors++; $display("FAIL single_ce got %h exp 55", ceo); end
  endtask

  task automatic test_contention();
    do_reset();
    ordy = 1; iv = 2'b11; wc = 0; wx = 2'b11; rid[0] = 4; rid[1] = 9;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (ir !== ((k % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contend_grant c%0d got %b exp %b", k, ir, (k % 2) ? 2'b10 : 2'b01); end
      if (k > 0) begin
        checks++; if (rso !== ((k % 2) ? 5'd4 : 5'd9) || xwe !== 1'b1) begin errors++; $display("FAIL contend_out c%0d got %0d/%b exp %0d/1", k, rso, xwe, (k % 2) ? 4 : 9); end
      end
      tick();
    end
    iv = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ordy = 0; iv = 2'b01; wc = 2'b01; wx = 0; rid[0] = 1;
    #1;
    checks++; if (ir !== 2'b01) begin errors++; $display("FAIL bp_push0 got %b exp 01", ir); end
    tick(); rid[0] = 2; #1;
    checks++; if (ir !== 2'b01 || rso !== 5'd1) begin errors++; $display("FAIL bp_push1 got %b/%0d exp 01/1", ir, rso); end
    tick(); rid[0] = 3; #1;
    checks++; if (ir !== 2'b00 || rso !== 5'd1) begin errors++; $display("FAIL bp_full got %b/%0d exp 00/1", ir, rso); end
    tick(); #1;
    checks++; if (ir !== 2'b00 || rso !== 5'd1 || ov !== 1'b1 || cwe !== 1'b1) begin errors++; $display("FAIL bp_hold got %b/%0d/%b/%b exp 00/1/1/1", ir, rso, ov, cwe); end
    ordy = 1; #1;
    checks++; if (ir !== 2'b01) begin errors++; $display("FAIL bp_poppush got %b exp 01", ir); end
    tick(); ordy = 0; iv = 0; #1;
    checks++; if (ov !== 1'b1 || rso !== 5'd2) begin errors++; $display("FAIL bp_advance got %b/%0d exp 1/2", ov, rso); end
    ordy = 1;
    tick(); #1;
    checks++; if (ov !== 1'b1 || rso !== 5'd3) begin errors++; $display("FAIL bp_tail got %b/%0d exp 1/3", ov, rso); end
    tick(); #1;
    checks++; if (ov !== 1'b0 || {cwe, xwe} !== 2'b00) begin errors++; $display("FAIL bp_empty got %b/%b exp 0/00", ov, {cwe, xwe}); end
  endtask

  task automatic test_bypass();
    do_reset();
    iv = 2'b11; wc = 2'b01; wx = 2'b00; rid[0] = 7; rid[1] = 12;
    #1;
    checks++; if (ir !== 2'b11) begin errors++; $display("FAIL bypass_ready got %b exp 11", ir); end
    tick(); iv = 0; #1;
    checks++; if (ov !== 1'b1 || rso !== 5'd7) begin errors++; $display("FAIL bypass_out got %b/%0d exp 1/7", ov, rso); end
    ordy = 1;
    tick(); #1;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL bypass_single got %b exp 0", ov); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    iv = 2'b01; wc = 2'b01; wx = 0; rid[0] = 1;
    tick(); rid[0] = 2;
    tick();
    rst = 1; #1;
    checks++; if (ir !== 2'b00) begin errors++; $display("FAIL midrst_ready got %b exp 00", ir); end
    tick();
    rst = 0; iv = 2'b11; wc = 2'b11; rid[0] = 5; rid[1] = 6;
    #1;
    checks++; if (ov !== 1'b0 || {cwe, xwe} !== 2'b00) begin errors++; $display("FAIL midrst_out got %b/%b exp 0/00", ov, {cwe, xwe}); end
    checks++; if (ir !== 2'b01) begin errors++; $display("FAIL midrst_grant got %b exp 01", ir); end
    tick(); iv = 0; #1;
    checks++; if (rso !== 5'd5) begin errors++; $display("FAIL midrst_first got %0d exp 5", rso); end
  endtask

  task automatic test_wrap();
    do_reset();
    ordy3 = 1; iv3 = 3'b010; wc3 = 3'b111; wx3 = 0;
    for (int i = 0; i < 3; i++) begin rid3[i] = 5'(10 + i); ce3[i] = '0; end
    #1;
    checks++; if (ir3 !== 3'b010) begin errors++; $display("FAIL wrap_g1 got %b exp 010", ir3); end
    tick(); iv3 = 3'b001; #1;
    checks++; if (ir3 !== 3'b001) begin errors++; $display("FAIL wrap_g0 got %b exp 001", ir3); end
    tick(); iv3 = 3'b011; #1;
    checks++; if (ir3 !== 3'b010) begin errors++; $display("FAIL wrap_ptr1 got %b exp 010", ir3); end
    checks++; if (ov3 !== 1'b1 || rso3 !== 5'd10) begin errors++; $display("FAIL wrap_out got %b/%0d exp 1/10", ov3, rso3); end
    tick(); iv3 = 0;
  endtask

  task automatic test_random();
    cr_xer_wb_entry_t mq[$];
    int ptr = 0, g;
    logic [1:0] exp_ir;
    logic pop, canp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!iv[i] || exp_ir[i] || c == 0) begin
          iv[i] = ($urandom % 4) != 0; wc[i] = $urandom % 2; wx[i] = $urandom % 2;
          rid[i] = 5'($urandom); ce[i] = cond_exception_t'(7'($urandom));
        end
      end
      ordy = ($urandom % 10) < 7;
      pop = (mq.size() > 0) && ordy;
      canp = (mq.size() < 2) || pop;
      g = -1;
      for (int k = 0; k < 2; k++) if (g < 0 && iv[(ptr + k) % 2] && (wc[(ptr + k) % 2] | wx[(ptr + k) % 2])) g = (ptr + k) % 2;
      for (int i = 0; i < 2; i++) exp_ir[i] = (iv[i] && !(wc[i] | wx[i])) || (i == g && canp);
      #1;
      checks++; if (ir !== exp_ir) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, ir, exp_ir); end
      checks++; if (ov !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid c%0d got %b exp %b", c, ov, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if ({rso, ceo, cwe, xwe} !== {mq[0].rs_id, mq[0].cr0_xer, mq[0].write_cr0, mq[0].write_xer})
          begin errors++; $display("FAIL rand_head c%0d got %0d/%h/%b%b exp %0d/%h/%b%b", c, rso, ceo, cwe, xwe, mq[0].rs_id, mq[0].cr0_xer, mq[0].write_cr0, mq[0].write_xer); end
      end else begin
        checks++; if ({cwe, xwe} !== 2'b00) begin errors++; $display("FAIL rand_empty_we c%0d got %b exp 00", c, {cwe, xwe}); end
      end
      if (pop) void'(mq.pop_front());
      if (g >= 0 && canp) begin
        mq.push_back('{rs_id: rid[g], write_cr0: wc[g], write_xer: wx[g], cr0_xer: ce[g]});
        ptr = (g + 1) % 2;
      end
      tick();
    end
    iv = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rid3[i] = 0; ce3[i] = '0; end
    rid[0] = 0; rid[1] = 0; ce[0] = '0; ce[1] = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cr_xer_write_back_arbiter.md
Name: cr_xer_write_back_arbiter

Overview:
- Shares the single CR0/XER condition write-back path between all execution units. Each unit's result port supplies a cond_exception_t.
- Selects one requester per cycle using round-robin and buffers the winner in a 2-entry output queue.
- The queue output drives the CR field-0 write port and the XER update of the SPR file. Each update is tagged with its RS ID so forwarding and tag-clearing work.
- Sits in ppc_core beside the GPR write-back arbiter and consumes the cr0_xer results the units already produce.

Parameters:
- RS_ID_WIDTH, 5, width of reservation-station IDs.
- ARBITER_DEPTH, 2, number of requesting units (1..16).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- input_valid  input  [0:ARBITER_DEPTH-1] x 1  per-unit request
- input_ready  output  [0:ARBITER_DEPTH-1] x 1  per-unit grant/accept
- rs_id_in  input  [0:ARBITER_DEPTH-1] x RS_ID_WIDTH  tag of the producing instruction
- write_cr0_in  input  [0:ARBITER_DEPTH-1] x 1  instruction alters CR0
- write_xer_in  input  [0:ARBITER_DEPTH-1] x 1  instruction alters XER (CA/OV/SO)
- cr0_xer_in  input  [0:ARBITER_DEPTH-1] x cond_exception_t  condition/exception result
- output_valid  output  1  head entry valid
- output_ready  input  1  consumer accepts head
- rs_id_out  output  RS_ID_WIDTH  head tag
- cr0_xer_out  output  cond_exception_t  head result
- cr_write_enable_0  output  1  output_valid & head.write_cr0
- xer_write_enable  output  1  output_valid & head.write_xer

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, rr_ptr=0.
  - All outputs 0: output_valid, input_ready, the write enables, rs_id_out and cr0_xer_out.
  - Queue contents are cleared to 0.
  - Reset mid-operation discards queued entries; no write enable is asserted in the cycle after reset.
- Request qualification: req[i] = input_valid[i] & (write_cr0_in[i] | write_xer_in[i]).
- Zero-effect results:
  - A valid input with neither flag set is accepted immediately (input_ready[i]=1) and is not queued.
  - Several such inputs may be accepted in the same cycle, independent of arbitration.
- Queue and accept rules:
  - Queue is 2 entries, in order; count is 0..2.
  - pop = output_valid & output_ready.
  - can_push = (count<2) | pop.
- Round-robin grant (combinational, same cycle):
  - Grant goes to the lowest i with req[i], searching from rr_ptr upward with wrap-around.
  - input_ready[i]=1 only for the granted i, and only when can_push=1.
- Transfer: a push occurs when the grant is given. Entry stored = {rs_id, write_cr0, write_xer, cr0_xer}.
- Pointer update:
  - On a push, rr_ptr becomes (grant+1) mod ARBITER_DEPTH.
  - With no push, rr_ptr holds.
- Latency: an accepted request appears on output_valid on the next clk edge (1 cycle) when the queue was empty.
- Simultaneous push and pop:
  - Allowed at count=1 and count=2; count is unchanged.
  - The head advances to the next entry; the new entry goes to the tail.
- Full (count=2, output_ready=0): all flagged input_ready are 0. Unit inputs must hold stable until accepted (valid/ready contract).
- Empty (count=0): output_valid=0, both write enables 0. rs_id_out and cr0_xer_out hold the last value and are don't-care.
- Output stability: while output_valid=1 and output_ready=0, all outputs remain stable.
- Single requester (ARBITER_DEPTH=1): rr_ptr is constant 0.

Decomposition:
- ppc_types gains cr_xer_wb_entry_t = {rs_id, write_cr0, write_xer, cond_exception_t}. The rs_id field is sized by a package constant RS_ID_WIDTH=5, shared with ppc_core.
- One sub-module, rr_grant, is natural: a combinational round-robin priority encoder with inputs req and ptr, outputs grant one-hot and grant_idx. The GPR arbiter can reuse it.
- The 2-entry queue is inline.

Test Plan:
1. Reset, then unit0 asserts valid with write_cr0=1, rs_id=3:
   - input_ready[0]=1 in that cycle.
   - Next cycle: output_valid=1, rs_id_out=3, cr_write_enable_0=1, xer_write_enable=0.
2. Contention with output_ready=1:
   - Both units request every cycle with write_xer=1, rs_ids 4 and 9.
   - Grants alternate 0,1,0,1; rs_id_out sequence is 4,9,4,9.
3. Backpressure:
   - output_ready=0 and unit0 requests continuously.
   - Two pushes occur, count reaches 2, then input_ready[0]=0 and outputs hold stable.
   - Raising output_ready for 1 cycle gives one pop and one push in that cycle, with count staying 2.
4. Zero-effect bypass:
   - Unit1 is valid with both flags 0 while unit0 is granted.
   - Both input_ready are 1 in the same cycle; only unit0's entry appears on the output.
5. Reset mid-operation:
   - Assert rst with count=2.
   - Next cycle: output_valid=0 and rr_ptr=0; the first post-reset grant goes to unit0 when both units request.
6. Wrap-around (ARBITER_DEPTH=3):
   - rr_ptr=2 and only unit0 requests: grant goes to 0 and rr_ptr becomes 1.
